// File: rtl/rvfi_trace_fifo.sv
// RVFI retirement capture: compacts up to NRET retire channels per cycle into one
// in-order FIFO and checks rvfi_order continuity. Optional memory fields: RVFI_TRACE_MEM_EN.
module rvfi_trace_fifo #(
  parameter int unsigned NRET  = 2,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16,
`ifdef RVFI_TRACE_MEM_EN
  localparam int unsigned MEM_W = 3*XLEN + 8,
`else
  localparam int unsigned MEM_W = 0,
`endif
  localparam int unsigned PKT_W = 64 + 32 + 1 + 3*XLEN + 5 + MEM_W,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clr,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [64*NRET-1:0]     rvfi_order,
  input  logic [32*NRET-1:0]     rvfi_insn,
  input  logic [NRET-1:0]        rvfi_trap,
  input  logic [XLEN*NRET-1:0]   rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]   rvfi_pc_wdata,
  input  logic [5*NRET-1:0]      rvfi_rd_addr,
  input  logic [XLEN*NRET-1:0]   rvfi_rd_wdata,
`ifdef RVFI_TRACE_MEM_EN
  input  logic [XLEN*NRET-1:0]   rvfi_mem_addr,
  input  logic [4*NRET-1:0]      rvfi_mem_rmask,
  input  logic [4*NRET-1:0]      rvfi_mem_wmask,
  input  logic [XLEN*NRET-1:0]   rvfi_mem_rdata,
  input  logic [XLEN*NRET-1:0]   rvfi_mem_wdata,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PKT_W-1:0]       out_pkt,
  output logic [LVL_W-1:0]       level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   order_err,
  output logic [63:0]            err_order
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CIN_W = $clog2(NRET + 1);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr, wptr;
  logic [63:0]      exp_order;

  logic [PKT_W-1:0] pkt_in [NRET];
  logic [PTR_W-1:0] slot_off [NRET];
  logic [CIN_W-1:0] n_in;
  logic             fits, push_ok, pop;
  logic [LVL_W-1:0] push_n;
  logic [CNT_W:0]   drop_sum;
  logic             err_hit;
  logic [63:0]      err_val, exp_k, exp_next;

  // Per-channel packet assembly and compaction offsets (lowest valid index first)
  always_comb begin
    n_in = '0;
    for (int i = 0; i < NRET; i++) begin
      pkt_in[i] = {rvfi_order[64*i +: 64], rvfi_insn[32*i +: 32], rvfi_trap[i],
                   rvfi_pc_rdata[XLEN*i +: XLEN], rvfi_pc_wdata[XLEN*i +: XLEN],
                   rvfi_rd_addr[5*i +: 5], rvfi_rd_wdata[XLEN*i +: XLEN]
`ifdef RVFI_TRACE_MEM_EN
                   , rvfi_mem_addr[XLEN*i +: XLEN], rvfi_mem_rmask[4*i +: 4],
                   rvfi_mem_wmask[4*i +: 4], rvfi_mem_rdata[XLEN*i +: XLEN],
                   rvfi_mem_wdata[XLEN*i +: XLEN]
`endif
                  };
      slot_off[i] = PTR_W'(n_in);
      if (rvfi_valid[i]) n_in = n_in + CIN_W'(1);
    end
  end

  // Order continuity: k-th valid channel must carry exp_order + k; resync to last + 1
  always_comb begin
    err_hit  = 1'b0;
    err_val  = '0;
    exp_k    = exp_order;
    exp_next = exp_order;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        if (!err_hit && (rvfi_order[64*i +: 64] != exp_k)) begin
          err_hit = 1'b1;
          err_val = rvfi_order[64*i +: 64];
        end
        exp_k    = exp_k + 64'd1;
        exp_next = rvfi_order[64*i +: 64] + 64'd1;
      end
    end
  end

  // All-or-nothing admission against start-of-cycle occupancy
  always_comb begin
    fits     = (LVL_W'(DEPTH) - level) >= LVL_W'(n_in);
    push_ok  = fits && (n_in != '0);
    push_n   = push_ok ? LVL_W'(n_in) : '0;
    pop      = out_valid && out_ready;
    drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_in);
  end

  assign out_valid = (level != '0);
  assign out_pkt   = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (!clr && push_ok) begin
      for (int i = 0; i < NRET; i++) begin
        if (rvfi_valid[i]) mem[PTR_W'(wptr + slot_off[i])] <= pkt_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr      <= '0;
      wptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      order_err <= 1'b0;
      err_order <= '0;
      exp_order <= '0;
    end else if (clr) begin
      rptr      <= '0;
      wptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      order_err <= 1'b0;
      err_order <= '0;
      exp_order <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(n_in);
      if (pop)     rptr <= rptr + PTR_W'(1);
      level <= level + push_n - LVL_W'(pop);
      if ((n_in != '0) && !fits) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
      if (err_hit && !order_err) begin
        order_err <= 1'b1;
        err_order <= err_val;
      end
      if (n_in != '0) exp_order <= exp_next;
    end
  end

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// Self-checking bench for rvfi_trace_fifo: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_rvfi_trace_fifo;

  localparam int unsigned NRET  = 2;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PKT_W = 64 + 32 + 1 + 3*XLEN + 5;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int          DROP_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn;
  logic clr;
  logic [NRET-1:0]      rvfi_valid;
  logic [64*NRET-1:0]   rvfi_order;
  logic [32*NRET-1:0]   rvfi_insn;
  logic [NRET-1:0]      rvfi_trap;
  logic [XLEN*NRET-1:0] rvfi_pc_rdata;
  logic [XLEN*NRET-1:0] rvfi_pc_wdata;
  logic [5*NRET-1:0]    rvfi_rd_addr;
  logic [XLEN*NRET-1:0] rvfi_rd_wdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [PKT_W-1:0]     out_pkt;
  logic [LVL_W-1:0]     level;
  logic                 overflow;
  logic [CNT_W-1:0]     drop_cnt;
  logic                 order_err;
  logic [63:0]          err_order;

  rvfi_trace_fifo #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .clr(clr),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .order_err(order_err), .err_order(err_order)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Reference model state
  logic [PKT_W-1:0] mq[$];
  logic             m_ovf;
  int               m_drop;
  logic             m_oerr;
  logic [63:0]      m_eord;
  logic [63:0]      m_exp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_drop = 0; m_oerr = 1'b0; m_eord = '0; m_exp = '0;
  endtask

  task automatic model_update();
    logic [PKT_W-1:0] pk[$];
    logic [63:0] o;
    bit popped;
    int space;
    if (clr) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        o = rvfi_order[64*i +: 64];
        if (!m_oerr && o != m_exp + 64'(pk.size())) begin
          m_oerr = 1'b1;
          m_eord = o;
        end
        pk.push_back({o, rvfi_insn[32*i +: 32], rvfi_trap[i], rvfi_pc_rdata[XLEN*i +: XLEN],
                      rvfi_pc_wdata[XLEN*i +: XLEN], rvfi_rd_addr[5*i +: 5],
                      rvfi_rd_wdata[XLEN*i +: XLEN]});
      end
    end
    if (pk.size() != 0) m_exp = pk[pk.size()-1][PKT_W-1 -: 64] + 64'd1;
    popped = (mq.size() != 0) && out_ready;
    space  = DEPTH - mq.size();
    if (popped) void'(mq.pop_front());
    if (pk.size() <= space) begin
      foreach (pk[k]) mq.push_back(pk[k]);
    end else begin
      m_ovf  = 1'b1;
      m_drop = (m_drop + pk.size() > DROP_MAX) ? DROP_MAX : m_drop + pk.size();
    end
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("level", 64'(level), 64'(mq.size()));
      if (mq.size() != 0) begin
        n_chk++;
        if (out_pkt !== mq[0]) begin
          n_err++;
          $display("FAIL out_pkt: got %h expected %h at %0t", out_pkt, mq[0], $time);
        end
      end
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("order_err", 64'(order_err), 64'(m_oerr));
      chk("err_order", err_order, m_eord);
    end
  end

  task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                       input logic rdy, input logic c);
    rvfi_valid = v;
    rvfi_order = {o1, o0};
    out_ready  = rdy;
    clr        = c;
    for (int i = 0; i < NRET; i++) begin
      rvfi_insn[32*i +: 32]       = $urandom;
      rvfi_trap[i]                = 1'($urandom);
      rvfi_pc_rdata[XLEN*i +: XLEN] = $urandom;
      rvfi_pc_wdata[XLEN*i +: XLEN] = $urandom;
      rvfi_rd_addr[5*i +: 5]      = 5'($urandom);
      rvfi_rd_wdata[XLEN*i +: XLEN] = (rvfi_rd_addr[5*i +: 5] == 5'd0) ? '0 : XLEN'($urandom);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && mq.size() != 0; k++) begin
      drive(2'b00, '0, '0, 1'b1, 1'b0);
      cyc();
    end
  endtask

  function automatic logic [63:0] head_order();
    return out_pkt[PKT_W-1 -: 64];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] so;
    logic [31:0] ins;
    int phase_rdy;
    resetn = 1'b0;
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    model_reset();
    #12;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pkt_zero", 64'(out_pkt != '0), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_order_err", 64'(order_err), 64'd0);
    chk("rst_err_order", err_order, 64'd0);
    resetn = 1'b1;
    chk_en = 1'b1;

    // Single channel, orders 0,1,2 with consumer ready
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 64'(k), 64'hdead, 1'b1, 1'b0);
      cyc();
      chk("single_head_order", head_order(), 64'(k));
      chk("single_level", 64'(level), 64'd1);
    end
    drain();
    chk("single_order_err", 64'(order_err), 64'd0);

    // Two channels at once: orders 3,4
    drive(2'b11, 64'd3, 64'd4, 1'b0, 1'b0);
    cyc();
    chk("dual_level", 64'(level), 64'd2);
    chk("dual_head0", head_order(), 64'd3);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    cyc();
    chk("dual_head1", head_order(), 64'd4);
    drain();

    // Non-contiguous valid: only channel 1 carries order 5
    drive(2'b10, 64'd99, 64'd5, 1'b0, 1'b0);
    ins = rvfi_insn[63:32];
    cyc();
    chk("nc_head_order", head_order(), 64'd5);
    chk("nc_head_insn", 64'(out_pkt[PKT_W-65 -: 32]), 64'(ins));
    chk("nc_level", 64'(level), 64'd1);
    chk("nc_order_err", 64'(order_err), 64'd0);
    drain();

    // Fill to 15 with consumer stalled, then overflow
    so = 64'd6;
    for (int k = 0; k < 7; k++) begin
      drive(2'b11, so, so + 64'd1, 1'b0, 1'b0);
      so += 64'd2;
      cyc();
    end
    drive(2'b01, so, '0, 1'b0, 1'b0);
    so += 64'd1;
    cyc();
    chk("fill_level15", 64'(level), 64'd15);
    drive(2'b11, so, so + 64'd1, 1'b0, 1'b0);
    so += 64'd2;
    cyc();
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop2", 64'(drop_cnt), 64'd2);
    chk("ovf_level15", 64'(level), 64'd15);
    drive(2'b01, so, '0, 1'b0, 1'b0);
    so += 64'd1;
    cyc();
    chk("ovf_resync_no_err", 64'(order_err), 64'd0);
    chk("full_level16", 64'(level), 64'd16);
    for (int k = 0; k < 9; k++) begin
      drive(2'b11, so, so + 64'd1, 1'b0, 1'b0);
      so += 64'd2;
      cyc();
    end
    chk("drop_saturated", 64'(drop_cnt), 64'(DROP_MAX));

    // Clear wins over a same-cycle push
    drive(2'b11, 64'd50, 64'd51, 1'b1, 1'b1);
    cyc();
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_drop_cnt", 64'(drop_cnt), 64'd0);
    drive(2'b01, 64'd0, '0, 1'b1, 1'b0);
    cyc();
    chk("clr_exp_zero", 64'(order_err), 64'd0);
    chk("clr_head0", head_order(), 64'd0);
    drain();

    // Order discontinuity: 0,1,3,4 then a later glitch is not recaptured
    drive(2'b00, '0, '0, 1'b1, 1'b1);
    cyc();
    drive(2'b11, 64'd0, 64'd1, 1'b1, 1'b0);
    cyc();
    drive(2'b11, 64'd3, 64'd4, 1'b1, 1'b0);
    cyc();
    chk("oerr_flag", 64'(order_err), 64'd1);
    chk("oerr_value", err_order, 64'd3);
    drive(2'b11, 64'd5, 64'd6, 1'b1, 1'b0);
    cyc();
    drive(2'b01, 64'd9, '0, 1'b1, 1'b0);
    cyc();
    chk("oerr_sticky", err_order, 64'd3);
    drain();

    // Randomized traffic, including a wrap of the 64-bit order and a mid-run reset
    drive(2'b00, '0, '0, 1'b1, 1'b1);
    cyc();
    so = '0;
    phase_rdy = 90;
    for (int it = 0; it < 3000; it++) begin
      logic [1:0] v;
      logic [63:0] o0, o1;
      if (it % 64 == 0) phase_rdy = (it % 192 == 0) ? 90 : ((it % 192 == 64) ? 50 : 10);
      if (it == 2000) so = 64'hFFFF_FFFF_FFFF_FFFC;
      if (it == 1500) begin
        resetn = 1'b0;
        #1;
        model_reset();
        chk("async_rst_level", 64'(level), 64'd0);
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        #1;
        resetn = 1'b1;
        so = '0;
      end
      v  = 2'($urandom);
      o0 = {$urandom, $urandom};
      o1 = {$urandom, $urandom};
      if ($urandom_range(0, 39) == 0) so += 64'($urandom_range(1, 5));
      if (v[0]) begin o0 = so; so += 64'd1; end
      if (v[1]) begin o1 = so; so += 64'd1; end
      drive(v, o0, o1, 1'($urandom_range(0, 99) < phase_rdy), 1'($urandom_range(0, 299) == 0));
      if (clr) so = '0;
      cyc();
    end
    drain();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rvfi_trace_fifo.md
Name: rvfi_trace_fifo

Overview:
- Parametrised RVFI retirement capture block: samples up to NRET retire channels per cycle, packs valid packets into one in-order FIFO, and drains them one per cycle over a valid/ready port to the scoreboard or trace writer.
- Checks that rvfi_order is contiguous across channels and cycles.
- Reports overflow and order errors through sticky flags.
- Sits between the DUT RVFI port and the checker in the verification environment.

Parameters:
- NRET, 2, number of retire channels per cycle (1..4).
- XLEN, 32, data/PC width.
- DEPTH, 16, FIFO entries; power of 2, >= NRET.
- CNT_W, 16, width of drop counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: empties FIFO, clears flags/counters, exp_order <= 0.
- rvfi_valid  in  NRET  per-channel retire valid.
- rvfi_order  in  64*NRET  per-channel order; channel i at [64*i +: 64].
- rvfi_insn  in  32*NRET  instruction word.
- rvfi_trap  in  NRET  trap flag.
- rvfi_pc_rdata  in  XLEN*NRET  PC of retired instruction.
- rvfi_pc_wdata  in  XLEN*NRET  next PC.
- rvfi_rd_addr  in  5*NRET  destination register.
- rvfi_rd_wdata  in  XLEN*NRET  rd write data (0 when rd_addr==0).
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_pkt  out  PKT_W  head packet: {order, insn, trap, pc_rdata, pc_wdata, rd_addr, rd_wdata}; PKT_W = 64+32+1+3*XLEN+5 (+mem fields, see Optional Feature).
- level  out  clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a cycle's packets were dropped.
- drop_cnt  out  CNT_W  packets dropped; saturating.
- order_err  out  1  sticky: order discontinuity seen.
- err_order  out  64  order value of first mismatching packet.

Behaviour:
- Reset (resetn=0, async): FIFO empty, level=0, out_valid=0, out_pkt=0, overflow=0, drop_cnt=0, order_err=0, err_order=0, exp_order=0.
- Priority: clr > push/pop. In a clr cycle the inputs are ignored.
- Push:
  - n_in = popcount(rvfi_valid).
  - Valid channels are compacted lowest index first into consecutive FIFO slots.
  - All-or-nothing: push all n_in if (DEPTH - level) >= n_in.
  - Otherwise push none, set overflow, and add n_in to drop_cnt, saturating at all-ones.
  - Free space uses level at the start of the cycle. A same-cycle pop does not create room.
- Pop: when out_valid && out_ready, head advances by 1. Simultaneous push and pop: level_next = level + pushed - popped.
- Output timing:
  - out_valid = (level != 0).
  - out_pkt is combinationally the head entry. Hold it stable while out_valid && !out_ready.
  - Write-to-read latency is 1 cycle: a packet pushed in cycle t is visible at the head in t+1 if the FIFO was empty.
  - No bypass.
- Order check (all valid inputs, accepted or dropped):
  - The k-th valid channel in index order is expected to carry exp_order + k.
  - On the first mismatch while order_err==0: set order_err and capture that packet's order into err_order.
  - exp_order_next = order of the highest-index valid channel + 1, whether or not it matched. This resyncs the check, so one glitch flags once.
  - If n_in == 0, exp_order is unchanged.
  - 64-bit arithmetic wraps modulo 2^64.
- Non-contiguous rvfi_valid (e.g. 2'b10) is legal and is compacted.
- Pointers: log2(DEPTH)-bit read/write pointers wrap naturally. Full is level==DEPTH, empty is level==0.
- Reset mid-operation: all in-flight entries are discarded. No partial packets.

Optional Feature:
- Macro RVFI_TRACE_MEM_EN.
- Defined:
  - Adds inputs rvfi_mem_addr (XLEN*NRET), rvfi_mem_rmask (4*NRET), rvfi_mem_wmask (4*NRET), rvfi_mem_rdata (XLEN*NRET), rvfi_mem_wdata (XLEN*NRET).
  - Appends {mem_addr, rmask, wmask, rdata, wdata} to out_pkt, giving PKT_W += 3*XLEN+8.
  - Storage and packing are otherwise identical.
- Undefined: these ports and fields are absent. No other behaviour changes.

Test Plan:
- Single channel, orders 0,1,2 on 3 consecutive cycles, out_ready=1 -> out_pkt.order = 0,1,2 on cycles 1,2,3; level never exceeds 1; order_err=0.
- NRET=2, rvfi_valid=2'b11 with orders 10,11 after exp_order resynced to 10 -> two entries pushed; out_pkt.order=10 then 11; level peaks at 2.
- rvfi_valid=2'b10 with ch1 order=5 while exp_order=5 -> one entry at the head holding ch1 data; no error; exp_order becomes 6.
- out_ready=0, DEPTH=16: fill to 15, then push 2 -> both dropped; overflow=1; drop_cnt=2; level stays 15; next expected order check continues from dropped order+1.
- Orders 0,1,3,4 -> order_err=1, err_order=3; orders 4 and onward raise no new capture; err_order stays 3.
- FIFO at level 8 with out_ready=1, assert clr together with a push -> next cycle level=0, out_valid=0, flags clear, exp_order=0; the clr-cycle push is ignored.
